// File: rtl/rr_pkg.sv
// Shared sizing helpers and default geometry for the on-the-fly converter.
// Digit width is K+1 (signed), word width is K*WIDTH+1 (two's complement).
package rr_pkg;

    function automatic int digit_bits(input int radix);
        return $clog2(radix) + 1;
    endfunction

    function automatic int word_bits(input int radix, input int width);
        return $clog2(radix) * width + 1;
    endfunction

    localparam int RADIX_DEF = 4;
    localparam int WIDTH_DEF = 4;
    localparam int K_DEF     = $clog2(RADIX_DEF);
    localparam int D_DEF     = digit_bits(RADIX_DEF);
    localparam int W_DEF     = word_bits(RADIX_DEF, WIDTH_DEF);

endpackage

// File: rtl/rr_otf_step.sv
// One on-the-fly conversion step: appends a signed digit to (Q, QM).
// Ports: digit_i, q_i, qm_i in; q_o, qm_o, illegal_o out. Combinational.
module rr_otf_step
    import rr_pkg::*;
#(
    parameter int K = K_DEF,
    parameter int W = W_DEF
) (
    input  logic [K:0]   digit_i,
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] qm_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] qm_o,
    output logic         illegal_o
);

    logic         neg;
    logic         pos;
    logic [K-1:0] dlo;
    logic [K-1:0] dm1;

    // RADIX+d and d share the low K bits, as do d-1 and RADIX-1+d,
    // so the appended field is just the low bits of d or d-1.
    assign neg       = digit_i[K];
    assign pos       = !neg && (|digit_i[K-1:0]);
    assign dlo       = digit_i[K-1:0];
    assign dm1       = dlo - 1'b1;
    assign illegal_o = (digit_i == {1'b1, {K{1'b0}}});

    assign q_o  = neg ? {qm_i[W-K-1:0], dlo}
                      : {q_i[W-K-1:0], dlo};
    assign qm_o = pos ? {q_i[W-K-1:0], dm1}
                      : {qm_i[W-K-1:0], dm1};

endmodule

// File: rtl/rr_otf_convert.sv
// MSD-first radix-RADIX digit stream to two's-complement word converter.
// Ports: clock, resetn, digit_in/in_first/in_valid/in_ready,
// q_out/out_valid/out_ready, err[0]=illegal digit, err[1]=framing.
module rr_otf_convert
    import rr_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int RADIX = RADIX_DEF,
    localparam int K     = $clog2(RADIX),
    localparam int D     = digit_bits(RADIX),
    localparam int W     = word_bits(RADIX, WIDTH)
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [D-1:0] digit_in,
    input  logic         in_first,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] q_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  qm_q, qm_d;
    logic [W-1:0]  qout_q, qout_d;
    logic          oval_q, oval_d;
    logic [1:0]    err_q, err_d;

    logic          xfer;
    logic          start;
    logic [CW-1:0] idx;
    logic [W-1:0]  q_prev, qm_prev;
    logic [W-1:0]  q_nxt, qm_nxt;
    logic          illegal;

    // Only the final digit can stall, and only behind an unconsumed word.
    assign in_ready  = !(cnt_q == LAST && oval_q && !out_ready);
    assign xfer      = in_valid && in_ready;

    // A new word (by count or by in_first) restarts from Q=0, QM=-1.
    assign start     = in_first || (cnt_q == '0);
    assign idx       = in_first ? '0 : cnt_q;
    assign q_prev    = start ? '0 : q_q;
    assign qm_prev   = start ? '1 : qm_q;

    rr_otf_step #(
        .K(K),
        .W(W)
    ) u_step (
        .digit_i  (digit_in),
        .q_i      (q_prev),
        .qm_i     (qm_prev),
        .q_o      (q_nxt),
        .qm_o     (qm_nxt),
        .illegal_o(illegal)
    );

    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        qm_d   = qm_q;
        qout_d = qout_q;
        oval_d = oval_q;
        err_d  = err_q;

        if (out_ready) begin
            oval_d = 1'b0;
        end

        if (xfer) begin
            q_d  = q_nxt;
            qm_d = qm_nxt;
            if (illegal) begin
                err_d[0] = 1'b1;
            end
            if (in_first && cnt_q != '0) begin
                err_d[1] = 1'b1;
            end
            if (idx == LAST) begin
                cnt_d  = '0;
                qout_d = q_nxt;
                oval_d = 1'b1;
            end else begin
                cnt_d  = idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q  <= '0;
            q_q    <= '0;
            qm_q   <= '1;
            qout_q <= '0;
            oval_q <= 1'b0;
            err_q  <= 2'b00;
        end else begin
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            qm_q   <= qm_d;
            qout_q <= qout_d;
            oval_q <= oval_d;
            err_q  <= err_d;
        end
    end

    assign q_out     = qout_q;
    assign out_valid = oval_q;
    assign err       = err_q;

endmodule
